// File: rtl/fft_input_buffer_64_pkg.sv
// -----------------------------------------------------------------------------
// fft_input_buffer_64_pkg
// Shared constants for the 64-point FFT datapath: the input buffer, the
// radix-2 DIT pipeline (fft_stage_64) and the downstream magnitude stage.
// Contents:
//   N, LOG2N, DATA_W        : frame size, address width, sample width
//   FRAME_CNT_W             : width of the delivered-frame counter
//   PRESCALE_SHIFT          : shift used when FFT_IN_PRESCALE_EN is defined
//   bitrev6()               : LOG2N-bit bit reversal
// -----------------------------------------------------------------------------
package fft_input_buffer_64_pkg;

  localparam int N              = 64;
  localparam int LOG2N          = 6;
  localparam int DATA_W         = 32;
  localparam int FRAME_CNT_W    = 16;
  localparam int PRESCALE_SHIFT = 6;

  // Write counter value of the final sample in a frame.
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_buffer_64_bitrev_addr.sv
// -----------------------------------------------------------------------------
// fft_bitrev_addr
// Combinational bit-reversed address generator. It maps a sample's arrival
// index to the bank slot that makes the first DIT stage see butterfly
// partners at distance 1.
// Ports:
//   wr_cnt   : LOG2N-bit arrival index
//   rev_addr : LOG2N-bit bit-reversed bank address
// -----------------------------------------------------------------------------
module fft_bitrev_addr
  import fft_input_buffer_64_pkg::*;
(
  input  logic [LOG2N-1:0] wr_cnt,
  output logic [LOG2N-1:0] rev_addr
);

  assign rev_addr = bitrev6(wr_cnt);

endmodule

// File: rtl/fft_input_buffer_64.sv
// -----------------------------------------------------------------------------
// fft_input_buffer_64
// Serial-to-parallel frame collector feeding the 64-point DIT pipeline.
// Samples are written into a ping-pong bank at bit-reversed addresses. When
// the 64th sample is accepted, the filled bank (including that sample) is
// copied to data_real_out_flat and frame_valid strobes for one cycle.
//
// Handshake: a sample is accepted on a rising clk edge where
// in_valid & in_ready is high. in_ready is 0 in reset and 1 from the first
// edge after reset release; there is no backpressure.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_data/valid/last  : sample stream, in_last tags sample 63
//   in_ready            : accept enable
//   flush               : synchronous discard of the partial frame (wins
//                         over a simultaneous accept)
//   data_real_out_flat  : frame, element k at bits [32k +: 32]
//   frame_valid         : one-cycle frame strobe (drives fft_stage_64 ready)
//   frame_err           : one-cycle framing-error strobe
//   frame_cnt           : delivered-frame count, wraps
//
// Build option: FFT_IN_PRESCALE_EN stores in_data >>> PRESCALE_SHIFT.
// -----------------------------------------------------------------------------
module fft_input_buffer_64
  import fft_input_buffer_64_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [N*DATA_W-1:0]     data_real_out_flat,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  logic [LOG2N-1:0]                 wr_cnt;
  logic                             fill_bank;
  logic [1:0][N-1:0][DATA_W-1:0]    bank;
  logic [LOG2N-1:0]                 wr_addr;
  logic [DATA_W-1:0]                wr_sample;
  logic                             accept;
  logic                             early_last;
  logic                             complete;
  logic [N*DATA_W-1:0]              frame_next;

  fft_bitrev_addr u_bitrev_addr (
    .wr_cnt   (wr_cnt),
    .rev_addr (wr_addr)
  );

`ifdef FFT_IN_PRESCALE_EN
  assign wr_sample = DATA_W'($signed(in_data) >>> PRESCALE_SHIFT);
`else
  assign wr_sample = in_data;
`endif

  assign accept     = in_valid & in_ready & ~flush;
  assign early_last = accept & in_last & (wr_cnt != LAST_IDX);
  assign complete   = accept & (wr_cnt == LAST_IDX);

  // The completing sample is written on the same edge the frame is loaded,
  // so merge it into the snapshot instead of reading it back from the bank.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < N; k++) begin
      frame_next[k*DATA_W +: DATA_W] =
        (LOG2N'(k) == wr_addr) ? wr_sample : bank[fill_bank][k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready           <= 1'b0;
      wr_cnt             <= '0;
      fill_bank          <= 1'b0;
      bank               <= '0;
      data_real_out_flat <= '0;
      frame_valid        <= 1'b0;
      frame_err          <= 1'b0;
      frame_cnt          <= '0;
    end else begin
      in_ready    <= 1'b1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (flush) begin
        wr_cnt <= '0;
      end else if (early_last) begin
        // Short frame: discard it, including the sample carrying in_last.
        frame_err <= 1'b1;
        wr_cnt    <= '0;
      end else if (accept) begin
        bank[fill_bank][wr_addr] <= wr_sample;
        if (complete) begin
          data_real_out_flat <= frame_next;
          frame_valid        <= 1'b1;
          // Missing in_last on sample 63 means the source lost sync.
          frame_err          <= ~in_last;
          fill_bank          <= ~fill_bank;
          wr_cnt             <= '0;
          frame_cnt          <= frame_cnt + 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_buffer_64.sv
// -----------------------------------------------------------------------------
// tb_fft_input_buffer_64
// Directed bench for fft_input_buffer_64. Drivers push the expected strobe
// (frame or framing error) into exp_q when the stimulus is issued; a monitor
// pops and compares whenever frame_valid or frame_err is seen.
// -----------------------------------------------------------------------------
module tb_fft_input_buffer_64;

  localparam int N      = 64;
  localparam int DATA_W = 32;
  localparam int FW     = N * DATA_W;

`ifdef FFT_IN_PRESCALE_EN
  localparam logic [31:0] EXP_PRE = 32'hFFFF_FFFE;   // -2
`else
  localparam logic [31:0] EXP_PRE = 32'hFFFF_FF80;   // -128
`endif

  typedef struct packed {
    logic          v;
    logic          e;
    logic [15:0]   cnt;
    logic [31:0]   cyc;
    logic [FW-1:0] data;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // clock / reset
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic [FW-1:0]     data_real_out_flat;
  logic              frame_valid;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  always #5 clk = ~clk;

  fft_input_buffer_64 dut (
    .clk                (clk),
    .rst                (rst),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .flush              (flush),
    .data_real_out_flat (data_real_out_flat),
    .frame_valid        (frame_valid),
    .frame_err          (frame_err),
    .frame_cnt          (frame_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass = 0;
  logic [FW-1:0]    last_flat = '0;
  logic             ready_expect = 1'b0;
  logic             ready_drop = 1'b0;

  // bench-side reference of the write side
  int            mdl_wr = 0;
  logic [FW-1:0] mdl_stage = '0;
  logic [15:0]   mdl_cnt = '0;

  function automatic int tb_bitrev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) if (a[i]) r |= (1 << (5 - i));
    return r;
  endfunction

  function automatic logic [31:0] scale(input logic [31:0] v);
`ifdef FFT_IN_PRESCALE_EN
    return 32'($signed(v) >>> 6);
`else
    return v;
`endif
  endfunction

  function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    for (int k = 0; k < N; k++) begin
      if (a[k*DATA_W +: DATA_W] !== b[k*DATA_W +: DATA_W]) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int k;
    k = first_diff(act, exp);
    n_checks++;
    if (k < 0) n_pass++;
    else $display("FAIL %s: element %0d got 0x%08h expected 0x%08h (cycle %0d)", name, k,
                  act[k*DATA_W +: DATA_W], exp[k*DATA_W +: DATA_W], cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ready_expect && !in_ready) ready_drop <= 1'b1;
      if (frame_valid || frame_err) begin
        exp_t e;
        check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_t'(exp_q.pop_front());
          check("strobe_cycle", cyc, e.cyc);
          check("frame_valid", 32'(frame_valid), 32'(e.v));
          check("frame_err", 32'(frame_err), 32'(e.e));
          check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
          if (e.v) check_frame("frame_data", data_real_out_flat, e.data);
        end
        if (frame_valid) last_flat <= data_real_out_flat;
      end
    end
  end

  // drivers
  task automatic drive_sample(input logic [31:0] v, input logic last, input logic fl);
    exp_t e;
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    in_last  = last;
    flush    = fl;
    if (fl) begin
      mdl_wr = 0;
    end else if (last && mdl_wr != 63) begin
      e = '{v: 1'b0, e: 1'b1, cnt: mdl_cnt, cyc: 32'(cyc + 1), data: '0};
      exp_q.push_back(EXP_W'(e));
      mdl_wr = 0;
    end else begin
      mdl_stage[tb_bitrev(mdl_wr)*DATA_W +: DATA_W] = scale(v);
      if (mdl_wr == 63) begin
        mdl_cnt = mdl_cnt + 16'd1;
        e = '{v: 1'b1, e: !last, cnt: mdl_cnt, cyc: 32'(cyc + 1), data: mdl_stage};
        exp_q.push_back(EXP_W'(e));
        mdl_wr = 0;
      end else begin
        mdl_wr++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // n samples of base + step*i; in_last on index last_idx (-1 for none)
  task automatic send_seq(input int n, input int base, input int step, input int last_idx);
    for (int i = 0; i < n; i++) begin
      drive_sample(32'(base + step * i), (i == last_idx), 1'b0);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
    ready_expect = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_frame("rst_data", data_real_out_flat, '0);
    mdl_wr  = 0;
    mdl_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", 32'(in_ready), 32'd1);
    ready_expect = 1'b1;
  endtask

  initial begin
    reset_pulse();

    // ramp: element k = bitrev6(k)
    send_seq(64, 0, 1, 63);
    idle(3);
    check("ramp_elem1", last_flat[1*DATA_W +: DATA_W], 32'd32);
    check("ramp_elem3", last_flat[3*DATA_W +: DATA_W], 32'd48);
    check("ramp_elem62", last_flat[62*DATA_W +: DATA_W], 32'd31);
    check("ramp_cnt", 32'(frame_cnt), 32'd1);

    // back-to-back frames, no gaps
    for (int f = 0; f < 3; f++) send_seq(64, f * 100, 1, 63);
    idle(3);
    check("b2b_cnt", 32'(frame_cnt), 32'd4);
    check("b2b_elem1", last_flat[1*DATA_W +: DATA_W], 32'd232);

    // early last on sample 9, then a clean frame
    send_seq(10, 500, 1, 9);
    send_seq(64, 1000, 1, 63);
    idle(3);
    check("early_cnt", 32'(frame_cnt), 32'd5);

    // missing last
    send_seq(64, 2000, 3, -1);
    idle(3);

    // flush after 20 samples (flush wins over a valid sample), fresh frame
    send_seq(20, 3000, 1, -1);
    drive_sample(32'hDEAD_BEEF, 1'b0, 1'b1);
    send_seq(64, 4000, 1, 63);
    idle(3);
    check("flush_elem0", last_flat[0 +: DATA_W], 32'd4000);

    // flush on a would-be completion
    send_seq(63, 5000, 1, -1);
    drive_sample(32'h0BAD_0BAD, 1'b1, 1'b1);
    send_seq(64, 6000, 1, 63);
    idle(3);

    // prescale build option
    send_seq(64, -128, 0, 63);
    idle(3);
    check("prescale_elem0", last_flat[0 +: DATA_W], EXP_PRE);
    check("prescale_elem63", last_flat[63*DATA_W +: DATA_W], EXP_PRE);

    // reset mid-frame, then a ramp restarts the count
    send_seq(30, 7000, 1, -1);
    reset_pulse();
    send_seq(64, 0, 1, 63);
    idle(3);
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);

    idle(4);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    check("in_ready_never_dropped", 32'(ready_drop), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
